// File: rtl/decoder_scan_pkg.sv
// ============================================================================
// Module : decoder_scan_pkg
// Brief  : Shared types and helpers for the decoder family.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_scan_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // Constant-foldable ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_onehot_n.sv
// ============================================================================
// Module : decoder_onehot_n
// Brief  : Combinational SEL_W -> 2**SEL_W active-low one-hot decoder with enable.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_onehot_n #(
  parameter int SEL_W = 2
) (
  input  logic                    g_n,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   y_n
);

  localparam int NUM_OUT = 1 << SEL_W;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign y_n[i] = g_n | (sel != SEL_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/decoder_scan.sv
// ============================================================================
// Module : decoder_scan
// Brief  : Registered active-low 1-of-2**SEL_W decoder with address latch and
//          auto-scan sequencer (programmable dwell per output).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int DWELL     = 4,
  parameter int SCAN_LAST = (1 << SEL_W) - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    g_n,
  input  logic                    le_n,
  input  logic                    scan,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   y_n,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap
);

  localparam int NUM_OUT = 1 << SEL_W;
  localparam int CNT_W   = (clog2(DWELL) > 1) ? clog2(DWELL) : 1;

  if (SEL_W < 1) begin : g_bad_sel_w
    $error("decoder_scan: SEL_W must be >= 1");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("decoder_scan: DWELL must be >= 1");
  end
  if (SCAN_LAST >= NUM_OUT || SCAN_LAST < 0) begin : g_bad_scan_last
    $error("decoder_scan: SCAN_LAST must be in 0..NUM_OUT-1");
  end

  localparam logic [CNT_W-1:0] c_dwell_last = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] c_scan_last  = SEL_W'(SCAN_LAST);

  logic [SEL_W-1:0]   r_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wrap;
  logic [NUM_OUT-1:0] r_y_n;

  logic [SEL_W-1:0]   w_addr_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_wrap_next;
  logic [NUM_OUT-1:0] w_y_n;
  mode_e              w_mode;

  assign w_mode = mode_e'(scan);

  // Direct mode keeps the counter at zero, so entering scan always starts a
  // fresh dwell on the address currently held.
  always_comb begin
    w_addr_next = r_addr;
    w_cnt_next  = r_cnt;
    w_wrap_next = 1'b0;
    if (w_mode == MODE_DIRECT) begin
      w_cnt_next = '0;
      if (!le_n) w_addr_next = sel;
    end else if (!g_n) begin
      if (r_cnt == c_dwell_last) begin
        w_cnt_next = '0;
        if (r_addr >= c_scan_last) begin
          w_addr_next = '0;
          w_wrap_next = 1'b1;
        end else begin
          w_addr_next = r_addr + SEL_W'(1);
        end
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  decoder_onehot_n #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .g_n (g_n),
    .sel (w_addr_next),
    .y_n (w_y_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_y_n  <= '1;
    end else begin
      r_addr <= w_addr_next;
      r_cnt  <= w_cnt_next;
      r_wrap <= w_wrap_next;
      r_y_n  <= w_y_n;
    end
  end

  assign y_n     = r_y_n;
  assign cur_sel = r_addr;
  assign wrap    = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_scan.sv
// ============================================================================
// Module : tb_decoder_scan
// Brief  : Self-checking bench for decoder_scan (two parameter sets).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       g_n_a, le_n_a, scan_a;
  logic [1:0] sel_a;
  logic [3:0] y_n_a;
  logic [1:0] cur_sel_a;
  logic       wrap_a;
  logic       g_n_b, le_n_b, scan_b;
  logic [1:0] sel_b;
  logic [3:0] y_n_b;
  logic [1:0] cur_sel_b;
  logic       wrap_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: address held, cycles left on it, wrap flag, outputs.
  int m_addr[2];
  int m_left[2];
  int m_wrap[2];
  int m_y[2];

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .DWELL(3), .SCAN_LAST(3)) dut_a (
    .clk(clk), .rst(rst), .g_n(g_n_a), .le_n(le_n_a), .scan(scan_a),
    .sel(sel_a), .y_n(y_n_a), .cur_sel(cur_sel_a), .wrap(wrap_a)
  );

  decoder_scan #(.SEL_W(2), .DWELL(1), .SCAN_LAST(2)) dut_b (
    .clk(clk), .rst(rst), .g_n(g_n_b), .le_n(le_n_b), .scan(scan_b),
    .sel(sel_b), .y_n(y_n_b), .cur_sel(cur_sel_b), .wrap(wrap_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int k, input int dwell, input int last, input bit r,
                            input bit g, input bit le, input bit sc, input int s);
    if (r) begin
      m_addr[k] = 0;
      m_left[k] = dwell;
      m_wrap[k] = 0;
    end else begin
      m_wrap[k] = 0;
      if (!sc) begin
        m_left[k] = dwell;
        if (!le) m_addr[k] = s;
      end else if (!g) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          m_left[k] = dwell;
          if (m_addr[k] >= last) begin
            m_addr[k] = 0;
            m_wrap[k] = 1;
          end else begin
            m_addr[k] = m_addr[k] + 1;
          end
        end
      end
    end
    m_y[k] = (r || g) ? 15 : (15 ^ (1 << m_addr[k]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 3, 3, rst, g_n_a, le_n_a, scan_a, int'(sel_a));
    model_edge(1, 1, 2, rst, g_n_b, le_n_b, scan_b, int'(sel_b));
    #1;
    check("a_y_n", y_n_a, m_y[0]);
    check("a_cur_sel", cur_sel_a, m_addr[0]);
    check("a_wrap", wrap_a, m_wrap[0]);
    check("b_y_n", y_n_b, m_y[1]);
    check("b_cur_sel", cur_sel_b, m_addr[1]);
    check("b_wrap", wrap_b, m_wrap[1]);
  endtask

  initial begin
    logic [3:0] e;

    // Reset with random other inputs
    rst = 1'b1;
    g_n_a = 1'($urandom); le_n_a = 1'($urandom); scan_a = 1'($urandom); sel_a = 2'($urandom);
    g_n_b = 1'($urandom); le_n_b = 1'($urandom); scan_b = 1'($urandom); sel_b = 2'($urandom);
    step();
    step();
    check("rst_y_n", y_n_a, 4'b1111);
    check("rst_cur_sel", cur_sel_a, 2'd0);
    check("rst_wrap", wrap_a, 1'b0);
    rst = 1'b0;

    // Direct mode latch
    g_n_a = 1'b0; le_n_a = 1'b0; scan_a = 1'b0; sel_a = 2'd2;
    g_n_b = 1'b1; le_n_b = 1'b1; scan_b = 1'b0; sel_b = 2'd0;
    step();
    check("latch_y_n", y_n_a, 4'b1011);
    check("latch_cur_sel", cur_sel_a, 2'd2);
    le_n_a = 1'b1; sel_a = 2'd1;
    step();
    check("hold_y_n", y_n_a, 4'b1011);

    // Direct mode blanking
    g_n_a = 1'b1;
    step();
    check("blank_y_n", y_n_a, 4'b1111);
    check("blank_cur_sel", cur_sel_a, 2'd2);
    g_n_a = 1'b0;
    step();
    check("unblank_y_n", y_n_a, 4'b1011);

    // Scan from address 0 over three periods
    le_n_a = 1'b0; sel_a = 2'd0;
    step();
    scan_a = 1'b1; le_n_a = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      sel_a = 2'($urandom);
      step();
      e = 4'hF ^ (4'h1 << ((i / 3) % 4));
      check("scan_y_n", y_n_a, e);
      check("scan_wrap", wrap_a, (i % 12) == 0);
    end

    // Pause on address 1 after its first dwell cycle
    for (int i = 0; i < 3; i++) step();
    check("pre_pause_cur_sel", cur_sel_a, 2'd1);
    g_n_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("pause_y_n", y_n_a, 4'b1111);
      check("pause_cur_sel", cur_sel_a, 2'd1);
      check("pause_wrap", wrap_a, 1'b0);
    end
    g_n_a = 1'b0;
    step();
    check("resume1_y_n", y_n_a, 4'b1101);
    step();
    check("resume2_y_n", y_n_a, 4'b1101);
    step();
    check("resume3_y_n", y_n_a, 4'b1011);

    // DWELL=1, SCAN_LAST=2: entry above SCAN_LAST wraps on the first edge
    g_n_b = 1'b0; le_n_b = 1'b0; sel_b = 2'd3; scan_b = 1'b0;
    step();
    check("b_direct_cur_sel", cur_sel_b, 2'd3);
    scan_b = 1'b1; le_n_b = 1'b1;
    step();
    check("b_s1_cur_sel", cur_sel_b, 2'd0);
    check("b_s1_wrap", wrap_b, 1'b1);
    step();
    check("b_s2_cur_sel", cur_sel_b, 2'd1);
    check("b_s2_wrap", wrap_b, 1'b0);
    step();
    check("b_s3_cur_sel", cur_sel_b, 2'd2);
    step();
    check("b_s4_cur_sel", cur_sel_b, 2'd0);
    check("b_s4_wrap", wrap_b, 1'b1);
    step();
    rst = 1'b1;
    step();
    check("b_midrst_y_n", y_n_b, 4'b1111);
    check("b_midrst_cur_sel", cur_sel_b, 2'd0);
    check("b_midrst_wrap", wrap_b, 1'b0);
    rst = 1'b0;

    // Randomised traffic on both instances
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      g_n_a  = ($urandom_range(0, 5) == 0);
      le_n_a = 1'($urandom);
      sel_a  = 2'($urandom);
      if ($urandom_range(0, 19) == 0) scan_a = ~scan_a;
      g_n_b  = ($urandom_range(0, 5) == 0);
      le_n_b = 1'($urandom);
      sel_b  = 2'($urandom);
      if ($urandom_range(0, 19) == 0) scan_b = ~scan_b;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
